audio_rom_arbiter: RTL and testbench

Shares one 16-bit SDRAM read channel among the three audio ROM consumers: theme sample playback (word reads), K007232 PCM (byte reads) and uPD7759 ADPCM (byte reads). Sits between the audio subsystem and the SDRAM controller's audio port. Sequences one SDRAM transaction at a time under fixed priority, maps each requester into its own SDRAM region, and extracts bytes for the 8-bit clients. Holds off all grants during ROM download.

---
 rtl/audio_rom_arbiter.sv | 239 +++++++++++++++++++++++
 tb/tb_audio_rom_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_rom_arbiter.sv
// audio_rom_arbiter
// Shares one 16-bit SDRAM read channel between theme playback (word reads),
// K007232 PCM (byte reads) and uPD7759 ADPCM (byte reads). One transaction at
// a time, fixed priority th > pcm > adp, each client mapped into its own SDRAM
// region. No new grants are made while a ROM download is in progress.
// Optional build macro AUDIO_ARB_WORDCACHE_EN adds a one-word cache each for
// pcm and adp so that a repeated read of the same word skips the SDRAM.
module audio_rom_arbiter #(
  parameter logic [21:0] THEME_BASE = 22'h000000,
  parameter logic [21:0] PCM_BASE   = 22'h040000,
  parameter logic [21:0] ADP_BASE   = 22'h050000,
  parameter logic [7:0]  TIMEOUT    = 8'd255
) (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        ioctl_download,
  input  logic        th_req,
  input  logic [17:0] th_addr,
  output logic        th_ack,
  output logic [15:0] th_data,
  input  logic        pcm_req,
  input  logic [16:0] pcm_addr,
  output logic        pcm_ack,
  output logic [7:0]  pcm_data,
  input  logic        adp_req,
  input  logic [16:0] adp_addr,
  output logic        adp_ack,
  output logic [7:0]  adp_data,
  output logic        sd_req,
  output logic [21:0] sd_addr,
  input  logic        sd_ack,
  input  logic [15:0] sd_dout,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;
  typedef enum logic [1:0] {GNT_NONE, GNT_TH, GNT_PCM, GNT_ADP} grant_e;

  state_e      state_q;
  grant_e      grant_q, grant_d;
  logic        bsel_q, bsel_d;
  logic [21:0] sd_addr_q, addr_d;
  logic        sd_req_q;
  logic [7:0]  cnt_q;

  logic        th_ack_q, pcm_ack_q, adp_ack_q;
  logic [15:0] th_data_q;
  logic [7:0]  pcm_data_q, adp_data_q;
  logic        timeout_err_q;

  logic        hit_d;
  logic [15:0] hit_word_d;

  logic        fin_d, fin_to_d, fin_bsel_d;
  grant_e      fin_grant_d;
  logic [15:0] fin_word_d;

  // Even byte address is the high byte of the SDRAM word.
  function automatic logic [7:0] pick_byte(input logic [15:0] w, input logic sel);
    return sel ? w[7:0] : w[15:8];
  endfunction

  // Fixed-priority choice among the current requests and its SDRAM word address.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant_d = GNT_NONE;
    addr_d  = '0;
    bsel_d  = 1'b0;
    if (th_req) begin
      grant_d = GNT_TH;
      addr_d  = THEME_BASE + {4'd0, th_addr};
    end else if (pcm_req) begin
      grant_d = GNT_PCM;
      addr_d  = PCM_BASE + {6'd0, pcm_addr[16:1]};
      bsel_d  = pcm_addr[0];
    end else if (adp_req) begin
      grant_d = GNT_ADP;
      addr_d  = ADP_BASE + {6'd0, adp_addr[16:1]};
      bsel_d  = adp_addr[0];
    end
  end

`ifdef AUDIO_ARB_WORDCACHE_EN
  logic        pcm_val_q, adp_val_q;
  logic [15:0] pcm_tag_q, adp_tag_q, pcm_word_q, adp_word_q;

  // Hit lookup for the granted byte client against its one-word cache.
  always_comb begin
    hit_d      = 1'b0;
    hit_word_d = '0;
    if (grant_d == GNT_PCM && pcm_val_q && pcm_tag_q == pcm_addr[16:1]) begin
      hit_d      = 1'b1;
      hit_word_d = pcm_word_q;
    end else if (grant_d == GNT_ADP && adp_val_q && adp_tag_q == adp_addr[16:1]) begin
      hit_d      = 1'b1;
      hit_word_d = adp_word_q;
    end
  end

  // Valid bits: download invalidates every cycle and wins over a fill.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      pcm_val_q <= 1'b0;
      adp_val_q <= 1'b0;
    end else if (ioctl_download) begin
      pcm_val_q <= 1'b0;
      adp_val_q <= 1'b0;
    end else if (state_q == WAIT && sd_ack) begin
      if (grant_q == GNT_PCM) pcm_val_q <= 1'b1;
      if (grant_q == GNT_ADP) adp_val_q <= 1'b1;
    end
  end

  // Tag and data storage, filled only by SDRAM replies (never by a timeout).
  // NOTE: storage behind a valid bit needs no reset; the valid bit guards it.
  // The tag is the word index, recovered from the latched address by removing the base.
  always_ff @(posedge clk_sys) begin
    if (state_q == WAIT && sd_ack) begin
      if (grant_q == GNT_PCM) begin
        pcm_tag_q  <= 16'(sd_addr_q - PCM_BASE);
        pcm_word_q <= sd_dout;
      end
      if (grant_q == GNT_ADP) begin
        adp_tag_q  <= 16'(sd_addr_q - ADP_BASE);
        adp_word_q <= sd_dout;
      end
    end
  end
`else
  assign hit_d      = 1'b0;
  assign hit_word_d = '0;
`endif

  // Transaction completion: cache hit from IDLE, SDRAM reply or timeout from WAIT.
  always_comb begin
    fin_d       = 1'b0;
    fin_to_d    = 1'b0;
    fin_grant_d = grant_q;
    fin_bsel_d  = bsel_q;
    fin_word_d  = sd_dout;
    case (state_q)
      IDLE: begin
        if (!ioctl_download && hit_d) begin
          fin_d       = 1'b1;
          fin_grant_d = grant_d;
          fin_bsel_d  = bsel_d;
          fin_word_d  = hit_word_d;
        end
      end
      WAIT: begin
        if (sd_ack) begin
          fin_d = 1'b1;
        end else if (cnt_q == TIMEOUT) begin
          fin_d      = 1'b1;
          fin_to_d   = 1'b1;
          fin_word_d = 16'hFFFF;
        end
      end
      default: ;
    endcase
  end

  // Sequencer: grant in IDLE, one-cycle SDRAM request, wait with timeout, ack.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    // NOTE: registers update with non-blocking assignments so all see pre-edge values.
    if (!nRESET) begin
      state_q   <= IDLE;
      grant_q   <= GNT_NONE;
      bsel_q    <= 1'b0;
      sd_addr_q <= '0;
      sd_req_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sd_req_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!ioctl_download && grant_d != GNT_NONE) begin
            grant_q   <= grant_d;
            bsel_q    <= bsel_d;
            sd_addr_q <= addr_d;
            if (hit_d) begin
              state_q <= DONE;
            end else begin
              sd_req_q <= 1'b1;
              state_q  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (fin_d) state_q <= DONE;
          else       cnt_q   <= cnt_q + 8'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered ack pulses, per-client data holding registers and sticky timeout flag.
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      th_ack_q      <= 1'b0;
      pcm_ack_q     <= 1'b0;
      adp_ack_q     <= 1'b0;
      th_data_q     <= '0;
      pcm_data_q    <= '0;
      adp_data_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      th_ack_q  <= fin_d && fin_grant_d == GNT_TH;
      pcm_ack_q <= fin_d && fin_grant_d == GNT_PCM;
      adp_ack_q <= fin_d && fin_grant_d == GNT_ADP;
      if (fin_d) begin
        case (fin_grant_d)
          GNT_TH:  th_data_q  <= fin_word_d;
          GNT_PCM: pcm_data_q <= pick_byte(fin_word_d, fin_bsel_d);
          GNT_ADP: adp_data_q <= pick_byte(fin_word_d, fin_bsel_d);
          default: ;
        endcase
      end
      if (fin_to_d) timeout_err_q <= 1'b1;
    end
  end

  assign th_ack      = th_ack_q;
  assign th_data     = th_data_q;
  assign pcm_ack     = pcm_ack_q;
  assign pcm_data    = pcm_data_q;
  assign adp_ack     = adp_ack_q;
  assign adp_data    = adp_data_q;
  assign sd_req      = sd_req_q;
  assign sd_addr     = sd_addr_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_audio_rom_arbiter.sv
// tb_audio_rom_arbiter: self-checking bench for audio_rom_arbiter. A behavioural
// SDRAM model answers each sd_req after a programmable delay; a request-level
// reference model predicts grant order, SDRAM addresses, latencies and data.
module tb_audio_rom_arbiter;

  localparam logic [21:0] THEME_BASE = 22'h000000;
  localparam logic [21:0] PCM_BASE   = 22'h040000;
  localparam logic [21:0] ADP_BASE   = 22'h050000;
  localparam int          TIMEOUT    = 255;
`ifdef AUDIO_ARB_WORDCACHE_EN
  localparam bit CACHE_EN = 1'b1;
`else
  localparam bit CACHE_EN = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        nRESET, ioctl_download;
  logic        th_req, pcm_req, adp_req;
  logic [17:0] th_addr;
  logic [16:0] pcm_addr, adp_addr;
  logic        th_ack, pcm_ack, adp_ack;
  logic [15:0] th_data;
  logic [7:0]  pcm_data, adp_data;
  logic        sd_req, sd_ack, timeout_err;
  logic [21:0] sd_addr;
  logic [15:0] sd_dout;

  audio_rom_arbiter dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .ioctl_download(ioctl_download),
    .th_req(th_req), .th_addr(th_addr), .th_ack(th_ack), .th_data(th_data),
    .pcm_req(pcm_req), .pcm_addr(pcm_addr), .pcm_ack(pcm_ack), .pcm_data(pcm_data),
    .adp_req(adp_req), .adp_addr(adp_addr), .adp_ack(adp_ack), .adp_data(adp_data),
    .sd_req(sd_req), .sd_addr(sd_addr), .sd_ack(sd_ack), .sd_dout(sd_dout),
    .timeout_err(timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SDRAM contents, filled lazily with random words.
  logic [15:0] mem [int];
  function automatic logic [15:0] mem_rd(input int a);
    if (!mem.exists(a)) mem[a] = 16'($urandom);
    return mem[a];
  endfunction

  // SDRAM model: sd_ack arrives sd_delay cycles after the cycle carrying sd_req.
  int sd_delay = 1;
  bit sd_mute  = 1'b0;
  initial begin
    int a;
    sd_ack  = 1'b0;
    sd_dout = 16'h0;
    forever begin
      @(negedge clk_sys);
      if (sd_req && !sd_mute) begin
        a = int'(sd_addr);
        repeat (sd_delay) @(negedge clk_sys);
        sd_ack  = 1'b1;
        sd_dout = mem_rd(a);
        @(negedge clk_sys);
        sd_ack  = 1'b0;
        sd_dout = 16'($urandom);
      end
    end
  end

  // Reference model: one expected completion per request.
  typedef struct {
    int          who;   // 0 theme, 1 pcm, 2 adp
    bit          hit;
    logic [21:0] addr;
    logic [15:0] data;  // byte clients: zero-extended byte
  } exp_t;

  bit          cval [3];
  logic [15:0] ctag [3];
  logic [15:0] cword[3];

  task automatic model_invalidate();
    for (int i = 0; i < 3; i++) cval[i] = 1'b0;
  endtask

  function automatic exp_t model_req(input int who, input logic [17:0] a);
    exp_t        e;
    logic [15:0] w;
    logic [15:0] idx;
    e.who = who;
    e.hit = 1'b0;
    if (who == 0) begin
      e.addr = THEME_BASE + 22'(a);
      e.data = mem_rd(int'(e.addr));
      return e;
    end
    idx    = a[16:1];
    e.addr = ((who == 1) ? PCM_BASE : ADP_BASE) + 22'(idx);
    if (CACHE_EN && cval[who] && ctag[who] == idx) begin
      e.hit = 1'b1;
      w     = cword[who];
    end else begin
      w = mem_rd(int'(e.addr));
      if (CACHE_EN) begin
        cval[who]  = 1'b1;
        ctag[who]  = idx;
        cword[who] = w;
      end
    end
    e.data = a[0] ? {8'h0, w[7:0]} : {8'h0, w[15:8]};
    return e;
  endfunction

  // Assert a set of simultaneous requests and check every grant and completion.
  task automatic run_round(input logic [2:0] mask, input logic [17:0] ta,
                           input logic [16:0] pa, input logic [16:0] aa, input int dly);
    exp_t        q[$];
    exp_t        e;
    logic [21:0] addr_q[$];
    logic [21:0] ea;
    logic [15:0] got;
    int          start_cyc, sdreq_cyc, budget, stray;
    bit          first;
    sd_delay = dly;
    if (mask[0]) q.push_back(model_req(0, ta));
    if (mask[1]) q.push_back(model_req(1, {1'b0, pa}));
    if (mask[2]) q.push_back(model_req(2, {1'b0, aa}));
    foreach (q[i]) if (!q[i].hit) addr_q.push_back(q[i].addr);
    @(negedge clk_sys);
    th_addr = ta; pcm_addr = pa; adp_addr = aa;
    th_req = mask[0]; pcm_req = mask[1]; adp_req = mask[2];
    start_cyc = cyc;
    sdreq_cyc = 0;
    budget    = 0;
    first     = 1'b1;
    while (q.size() > 0 && budget < 2000) begin
      @(negedge clk_sys);
      budget++;
      if (sd_req) begin
        checks++;
        sdreq_cyc = cyc;
        if (addr_q.size() == 0) begin
          errors++;
          $display("FAIL sd_req_unexpected got sd_addr=%h exp no request", sd_addr);
        end else begin
          ea = addr_q.pop_front();
          if (sd_addr !== ea) begin
            errors++;
            $display("FAIL sd_addr got %h exp %h", sd_addr, ea);
          end
        end
      end
      if (th_ack || pcm_ack || adp_ack) begin
        e = q.pop_front();
        checks++;
        if ({adp_ack, pcm_ack, th_ack} !== (3'b001 << e.who)) begin
          errors++;
          $display("FAIL grant_order got acks=%b exp %b", {adp_ack, pcm_ack, th_ack}, 3'b001 << e.who);
        end else begin
          got = (e.who == 0) ? th_data : (e.who == 1) ? {8'h0, pcm_data} : {8'h0, adp_data};
          checks++;
          if (got !== e.data) begin
            errors++;
            $display("FAIL ack_data client=%0d got %h exp %h", e.who, got, e.data);
          end
          checks++;
          if (first && e.hit && cyc != start_cyc + 1) begin
            errors++;
            $display("FAIL hit_latency got cycle %0d exp %0d", cyc, start_cyc + 1);
          end else if (first && !e.hit && cyc != start_cyc + dly + 2) begin
            errors++;
            $display("FAIL miss_latency got cycle %0d exp %0d", cyc, start_cyc + dly + 2);
          end else if (!e.hit && cyc != sdreq_cyc + dly + 1) begin
            errors++;
            $display("FAIL reply_latency got cycle %0d exp %0d", cyc, sdreq_cyc + dly + 1);
          end
        end
        first = 1'b0;
        if (th_ack)  th_req  = 1'b0;
        if (pcm_ack) pcm_req = 1'b0;
        if (adp_ack) adp_req = 1'b0;
      end
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL round_budget got %0d outstanding exp 0", q.size());
    end
    th_req = 1'b0; pcm_req = 1'b0; adp_req = 1'b0;
    stray = 0;
    repeat (3) begin
      @(negedge clk_sys);
      if (sd_req || th_ack || pcm_ack || adp_ack) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL round_stray got %0d events exp 0", stray);
    end
  endtask

  task automatic pulse_download();
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    repeat (2) @(negedge clk_sys);
    ioctl_download = 1'b0;
    model_invalidate();
  endtask

  task automatic test_reset();
    nRESET = 1'b0; ioctl_download = 1'b0;
    th_req = 1'b0; pcm_req = 1'b0; adp_req = 1'b0;
    th_addr = '0; pcm_addr = '0; adp_addr = '0;
    model_invalidate();
    repeat (3) @(negedge clk_sys);
    checks++;
    if ({th_ack, pcm_ack, adp_ack, sd_req, timeout_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b exp 00000", {th_ack, pcm_ack, adp_ack, sd_req, timeout_err});
    end
    checks++;
    if ({th_data, pcm_data, adp_data, sd_addr} !== 54'h0) begin
      errors++;
      $display("FAIL reset_data got %h exp 0", {th_data, pcm_data, adp_data, sd_addr});
    end
    nRESET = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_theme();
    mem[32'h10] = 16'hABCD;
    run_round(3'b001, 18'h00010, '0, '0, 2);
    run_round(3'b001, 18'h3FFFF, '0, '0, 1);
  endtask

  task automatic test_pcm_bytes();
    mem[32'h040001] = 16'h1234;
    run_round(3'b010, '0, 17'h00003, '0, 2);
    run_round(3'b010, '0, 17'h00002, '0, 1);
    run_round(3'b100, '0, '0, 17'h1FFFF, 3);
  endtask

  task automatic test_priority();
    run_round(3'b111, 18'($urandom), 17'($urandom), 17'($urandom), 1);
    run_round(3'b110, '0, 17'($urandom), 17'($urandom), 4);
  endtask

  task automatic test_random();
    logic [16:0] pa, aa;
    pa = 17'($urandom);
    aa = 17'($urandom);
    for (int i = 0; i < 40; i++) begin
      pa = ($urandom_range(0, 2) == 0) ? (pa ^ 17'd1) : 17'($urandom);
      aa = ($urandom_range(0, 2) == 0) ? aa : 17'($urandom);
      run_round(3'($urandom_range(1, 7)), 18'($urandom), pa, aa, $urandom_range(1, 6));
    end
  endtask

  task automatic test_download();
    int          ev, n;
    logic [16:0] pa;
    exp_t        e;
    @(negedge clk_sys);
    ioctl_download = 1'b1;
    adp_addr = 17'h00123;
    adp_req  = 1'b1;
    ev = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (sd_req || adp_ack) ev++;
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL download_hold got %0d events exp 0", ev);
    end
    adp_req = 1'b0;
    ioctl_download = 1'b0;
    model_invalidate();
    run_round(3'b100, '0, '0, 17'h00123, 1);
    // A cached word must be refetched after a download.
    pa = 17'($urandom);
    run_round(3'b010, '0, pa, '0, 1);
    pulse_download();
    run_round(3'b010, '0, pa, '0, 2);
    // Download rising while a fetch is in flight: the fetch still completes.
    pulse_download();
    e = model_req(1, {1'b0, pa});
    model_invalidate();
    sd_delay = 5;
    @(negedge clk_sys);
    pcm_addr = pa;
    pcm_req  = 1'b1;
    for (n = 0; n < 10 && !sd_req; n++) @(negedge clk_sys);
    ioctl_download = 1'b1;
    for (n = 0; n < 20 && !pcm_ack; n++) @(negedge clk_sys);
    checks++;
    if (!pcm_ack || {8'h0, pcm_data} !== e.data) begin
      errors++;
      $display("FAIL download_inflight got ack=%b data=%h exp ack=1 data=%h", pcm_ack, pcm_data, e.data[7:0]);
    end
    pcm_req = 1'b0;
    repeat (3) @(negedge clk_sys);
    ioctl_download = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_timeout();
    int          n, t_issue;
    logic [16:0] aa;
    pulse_download();
    aa = 17'($urandom);
    sd_mute = 1'b1;
    @(negedge clk_sys);
    adp_addr = aa;
    adp_req  = 1'b1;
    for (n = 0; n < 10 && !sd_req; n++) @(negedge clk_sys);
    t_issue = cyc;
    for (n = 0; n < 400 && !adp_ack; n++) @(negedge clk_sys);
    checks++;
    if (!adp_ack || cyc != t_issue + TIMEOUT + 2) begin
      errors++;
      $display("FAIL timeout_latency got ack=%b after %0d cycles exp %0d", adp_ack, cyc - t_issue, TIMEOUT + 2);
    end
    checks++;
    if (adp_data !== 8'hFF || timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_result got data=%h err=%b exp data=ff err=1", adp_data, timeout_err);
    end
    adp_req = 1'b0;
    sd_mute = 1'b0;
    repeat (2) @(negedge clk_sys);
    // The timed-out word was not cached, so this must go to SDRAM.
    run_round(3'b100, '0, '0, aa, 1);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b exp 1", timeout_err);
    end
  endtask

  task automatic test_reset_mid();
    int n, ev;
    sd_delay = 6;
    @(negedge clk_sys);
    th_addr = 18'($urandom);
    th_req  = 1'b1;
    for (n = 0; n < 10 && !sd_req; n++) @(negedge clk_sys);
    repeat (2) @(negedge clk_sys);
    nRESET = 1'b0;
    #1;
    checks++;
    if ({th_ack, pcm_ack, adp_ack, sd_req, timeout_err, th_data, pcm_data, adp_data, sd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_async got %h exp 0",
               {th_ack, pcm_ack, adp_ack, sd_req, timeout_err, th_data, pcm_data, adp_data, sd_addr});
    end
    th_req = 1'b0;
    model_invalidate();
    @(negedge clk_sys);
    nRESET = 1'b1;
    ev = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (th_ack || pcm_ack || adp_ack || sd_req) ev++;
    end
    checks++;
    if (ev != 0) begin
      errors++;
      $display("FAIL late_sd_ack got %0d events exp 0", ev);
    end
  endtask

  initial begin
    test_reset();
    test_theme();
    test_pcm_bytes();
    test_priority();
    test_random();
    test_download();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
